// File: rtl/shift_pkg.sv
// shift_pkg: opcodes, FSM state encoding and opcode legality check for iter_shift_unit
package shift_pkg;

   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ROR  = 5'b01100;
   localparam logic [4:0] OP_ROL  = 5'b01101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   function automatic logic is_legal(input logic [4:0] op);
      return op inside {OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL};
   endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-step shift/rotate of the work value by i_k bits
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic [4:0]       i_op,
   input  logic [WIDTH-1:0] i_data,
   input  logic [AMT_W-1:0] i_k,
   output logic [WIDTH-1:0] o_data
);

   logic [2*WIDTH-1:0] w_dbl_r;
   logic [2*WIDTH-1:0] w_dbl_l;
   logic [WIDTH-1:0]   w_sra;

   // rotates come from a doubled copy so no bit is lost; SHRA is kept separate to stay signed
   always_comb begin
      w_dbl_r = {i_data, i_data} >> i_k;
      w_dbl_l = {i_data, i_data} << i_k;
      w_sra   = $signed(i_data) >>> i_k;
      o_data  = (i_op == OP_SHR)  ? i_data >> i_k :
                (i_op == OP_SHRA) ? w_sra :
                (i_op == OP_SHL)  ? i_data << i_k :
                (i_op == OP_ROR)  ? w_dbl_r[WIDTH-1:0] :
                (i_op == OP_ROL)  ? w_dbl_l[2*WIDTH-1:WIDTH] : '0;
   end

endmodule

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: iterative STEP-bits-per-cycle shift/rotate unit with start/done handshake
module iter_shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [4:0]       i_opcode,
   input  logic [WIDTH-1:0] i_operand,
   input  logic [AMT_W-1:0] i_amount,
   input  logic             i_flush,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_illegal,
   output logic [WIDTH-1:0] o_result
);

   localparam logic [AMT_W:0] STEP_W = (AMT_W+1)'(STEP);

   state_t           r_state;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_result;
   logic [AMT_W-1:0] r_rem;
   logic [4:0]       r_op;
   logic             r_busy;
   logic             r_done;
   logic             r_illegal;
   logic [AMT_W-1:0] w_k;
   logic [AMT_W-1:0] w_rem_next;
   logic [WIDTH-1:0] w_shifted;

   // per-cycle shift is min(STEP, remaining); an amount of 0 yields a zero-bit step
   always_comb begin
      w_k        = ({1'b0, r_rem} < STEP_W) ? r_rem : STEP_W[AMT_W-1:0];
      w_rem_next = r_rem - w_k;
   end

   shift_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
      .i_op   (r_op),
      .i_data (r_work),
      .i_k    (w_k),
      .o_data (w_shifted)
   );

   // control FSM; result is loaded on entry to FIN so it is valid alongside done
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_work    <= '0;
         r_result  <= '0;
         r_rem     <= '0;
         r_op      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         if (i_flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start && is_legal(i_opcode)) begin
                     r_work  <= i_operand;
                     r_rem   <= i_amount;
                     r_op    <= i_opcode;
                     r_busy  <= 1'b1;
                     r_state <= S_RUN;
                  end else if (i_start) begin
                     r_illegal <= 1'b1;
                  end
               end
               S_RUN: begin
                  r_work <= w_shifted;
                  r_rem  <= w_rem_next;
                  if (w_rem_next == '0) begin
                     r_result <= w_shifted;
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_state  <= S_FIN;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_illegal = r_illegal;
   assign o_result  = r_result;

endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: directed + random checks of iter_shift_unit (32/1 and 16/4) against a bit-at-a-time model
module tb_iter_shift_unit;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_start = 1'b0, a_flush = 1'b0;
   logic [4:0]  a_op = '0;
   logic [31:0] a_val = '0;
   logic [4:0]  a_amt = '0;
   logic        a_busy, a_done, a_illegal;
   logic [31:0] a_res;
   logic        b_start = 1'b0, b_flush = 1'b0;
   logic [4:0]  b_op = '0;
   logic [15:0] b_val = '0;
   logic [3:0]  b_amt = '0;
   logic        b_busy, b_done, b_illegal;
   logic [15:0] b_res;

   int errs = 0;
   int checks = 0;
   logic [31:0] exp_a = '0;
   logic [31:0] exp_b = '0;
   logic [4:0]  ops [5] = '{OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL};

   always #5 clk = ~clk;

   iter_shift_unit #(.WIDTH(32), .STEP(1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_opcode(a_op), .i_operand(a_val),
      .i_amount(a_amt), .i_flush(a_flush), .o_busy(a_busy), .o_done(a_done),
      .o_illegal(a_illegal), .o_result(a_res)
   );

   iter_shift_unit #(.WIDTH(16), .STEP(4)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_opcode(b_op), .i_operand(b_val),
      .i_amount(b_amt), .i_flush(b_flush), .o_busy(b_busy), .o_done(b_done),
      .o_illegal(b_illegal), .o_result(b_res)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // shift one bit position at a time, amt times
   function automatic logic [31:0] ref_shift(input logic [4:0] op, input logic [31:0] v, input int amt, input int w);
      logic [31:0] mask, msb;
      mask = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
      msb  = 32'd1 << (w - 1);
      v    = v & mask;
      for (int i = 0; i < amt; i++) begin
         case (op)
            OP_SHR:  v = v >> 1;
            OP_SHRA: v = (v >> 1) | (v & msb);
            OP_SHL:  v = (v << 1) & mask;
            OP_ROR:  v = (v >> 1) | ((v & 32'd1) << (w - 1));
            OP_ROL:  v = ((v << 1) & mask) | (v >> (w - 1));
            default: v = v;
         endcase
      end
      return v;
   endfunction

   task automatic run_op(input bit w16, input logic [4:0] op, input logic [31:0] val, input int amt, input bit poke);
      int n, cnt, nb, st, w;
      bit extra;
      logic [31:0] exp;
      st  = w16 ? 4 : 1;
      w   = w16 ? 16 : 32;
      n   = (amt == 0) ? 1 : (amt + st - 1) / st;
      exp = ref_shift(op, val, amt, w);
      @(negedge clk);
      if (w16) begin b_start = 1'b1; b_op = op; b_val = val[15:0]; b_amt = 4'(amt); end
      else     begin a_start = 1'b1; a_op = op; a_val = val;       a_amt = 5'(amt); end
      @(posedge clk); #1;
      a_start = 1'b0; b_start = 1'b0;
      cnt = 0; nb = 0;
      while (!(w16 ? b_done : a_done) && cnt < 200) begin
         if (w16 ? b_busy : a_busy) nb++;
         if (poke && cnt == 3) begin a_start = 1'b1; a_op = OP_SHL; a_val = $urandom; a_amt = 5'd2; end
         else a_start = 1'b0;
         @(posedge clk); #1;
         cnt++;
      end
      a_start = 1'b0;
      chk("latency", 32'(cnt), 32'(n));
      chk("busy_cycles", 32'(nb), 32'(n));
      chk("result", w16 ? {16'h0, b_res} : a_res, exp);
      chk("busy_in_fin", 32'(w16 ? b_busy : a_busy), 32'd0);
      extra = 1'b0;
      repeat (poke ? 30 : 1) begin
         @(posedge clk); #1;
         if (w16 ? b_done : a_done) extra = 1'b1;
      end
      chk("single_done", 32'(extra), 32'd0);
      chk("result_held", w16 ? {16'h0, b_res} : a_res, exp);
      if (w16) exp_b = exp; else exp_a = exp;
   endtask

   initial begin
      bit seen;
      int r;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_illegal", 32'(a_illegal | b_illegal), 32'd0);
      chk("rst_result", a_res, 32'd0);
      chk("rst_result16", {16'h0, b_res}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      run_op(1'b0, OP_SHR,  32'd10,        1,  1'b0);
      run_op(1'b0, OP_SHRA, 32'h8000_0000, 4,  1'b0);
      run_op(1'b0, OP_ROL,  32'h8000_0001, 1,  1'b0);
      run_op(1'b0, OP_ROR,  32'h8000_0001, 31, 1'b0);
      run_op(1'b0, OP_SHL,  32'h1234_5678, 0,  1'b0);
      run_op(1'b0, OP_SHR,  32'hDEAD_BEEF, 20, 1'b1);
      run_op(1'b1, OP_SHR,  32'h0000_00F0, 4,  1'b0);
      run_op(1'b1, OP_SHRA, 32'h0000_8000, 7,  1'b0);
      run_op(1'b1, OP_ROL,  32'h0000_8001, 15, 1'b0);

      // flush in the third RUN cycle
      @(negedge clk);
      a_start = 1'b1; a_op = OP_SHR; a_val = 32'hFFFF_0000; a_amt = 5'd10;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      a_flush = 1'b1;
      a_start = 1'b1;
      @(posedge clk); #1;
      a_flush = 1'b0; a_start = 1'b0;
      chk("flush_busy", 32'(a_busy), 32'd0);
      chk("flush_done", 32'(a_done), 32'd0);
      chk("flush_result", a_res, exp_a);
      seen = 1'b0;
      repeat (15) begin @(posedge clk); #1; if (a_done || a_busy) seen = 1'b1; end
      chk("flush_no_done", 32'(seen), 32'd0);

      // illegal opcode
      @(negedge clk);
      a_start = 1'b1; a_op = 5'b00000; a_val = 32'h5555_5555; a_amt = 5'd3;
      @(posedge clk); #1;
      a_start = 1'b0;
      chk("illegal_pulse", 32'(a_illegal), 32'd1);
      chk("illegal_busy", 32'(a_busy), 32'd0);
      @(posedge clk); #1;
      chk("illegal_clear", 32'(a_illegal), 32'd0);
      chk("illegal_done", 32'(a_done), 32'd0);
      chk("illegal_result", a_res, exp_a);
      run_op(1'b0, OP_ROR, 32'h0000_00F1, 4, 1'b0);

      // randomized operations on both instances
      for (int i = 0; i < 25; i++) begin
         r = $urandom_range(0, 4);
         run_op(1'b0, ops[r], $urandom, $urandom_range(0, 31), 1'b0);
         r = $urandom_range(0, 4);
         run_op(1'b1, ops[r], $urandom, $urandom_range(0, 15), 1'b0);
      end

      // asynchronous clear mid-RUN
      @(negedge clk);
      a_start = 1'b1; a_op = OP_SHR; a_val = 32'hFFFF_FFFF; a_amt = 5'd20;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("clr_busy", 32'(a_busy), 32'd0);
      chk("clr_done", 32'(a_done), 32'd0);
      chk("clr_result", a_res, 32'd0);
      chk("clr_result16", {16'h0, b_res}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run_op(1'b0, OP_SHL, 32'h0000_0001, 31, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
